// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU pipeline constants, shadow stage record types and small helpers
// used by the hazard controller.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_E    = 2'd1;
  localparam logic [1:0] FWD_M    = 2'd2;
  localparam logic [1:0] FWD_W    = 2'd3;
  localparam logic [3:0] MULT_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT  = 4'd10;

  typedef struct packed {
    logic [4:0] a1;
    logic [4:0] a2;
    logic [4:0] a3;
    logic [1:0] tnew;
    logic       md_start;
    logic       md_div;
  } e_rec_t;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
  } mw_rec_t;

  function automatic logic [1:0] tnew_dec(input logic [1:0] tnew);
    return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
  endfunction

  // A stage can supply an operand once its result exists and it writes a real register.
  function automatic logic fwd_hit(input logic [4:0] src, input logic [4:0] a3,
                                   input logic [1:0] tnew);
    return (a3 != 5'd0) && (a3 == src) && (tnew == 2'd0);
  endfunction

  function automatic logic [1:0] fwd_pick(input logic hit_e, input logic hit_m,
                                          input logic hit_w);
    logic [1:0] sel;
    if (hit_e) begin
      sel = FWD_E;
    end else if (hit_m) begin
      sel = FWD_M;
    end else if (hit_w) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md.sv
// Mult/div occupancy counter: loads the unit latency when a start leaves E and
// counts down to idle.
module md_busy_cnt
  import hazard_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy
);

  logic [3:0] count_r;

  // Countdown register; a start while busy cannot occur because D stalls on it.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 4'd0;
    end else if (count_r != 4'd0) begin
      count_r <= count_r - 4'd1;
    end else if (start) begin
      count_r <= div ? DIV_LAT : MULT_LAT;
    end else begin
      count_r <= count_r;
    end
  end

  assign busy = (count_r != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks E/M/W destination records, raises the
// stall/flush for D and selects operand forwarding for D and E.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] A1_D,
  input  logic [4:0] A2_D,
  input  logic [1:0] Tuse_rs_D,
  input  logic [1:0] Tuse_rt_D,
  input  logic [4:0] A3_D,
  input  logic [1:0] Tnew_D_E,
  input  logic       md_use_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  output logic       Stall_F,
  output logic       Stall_D,
  output logic       Flush_E,
  output logic [1:0] Fwd_rs_D,
  output logic [1:0] Fwd_rt_D,
  output logic [1:0] Fwd_rs_E,
  output logic [1:0] Fwd_rt_E,
  output logic       md_busy
);

  e_rec_t  e_r;
  mw_rec_t m_r;
  mw_rec_t w_r;
  logic    stall_rs_s;
  logic    stall_rt_s;
  logic    stall_md_s;
  logic    stall_s;

  // Shadow pipeline: M and W always advance, E takes a zero bubble on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_r <= '0;
      m_r <= '0;
      w_r <= '0;
    end else begin
      if (stall_s) begin
        e_r <= '0;
      end else begin
        e_r <= '{a1: A1_D, a2: A2_D, a3: A3_D, tnew: Tnew_D_E,
                 md_start: md_start_D, md_div: md_div_D};
      end
      m_r <= '{a3: e_r.a3, tnew: tnew_dec(e_r.tnew)};
      w_r <= '{a3: m_r.a3, tnew: tnew_dec(m_r.tnew)};
    end
  end

  md_busy_cnt u_md_busy_cnt (
    .clk   (clk),
    .reset (reset),
    .start (e_r.md_start),
    .div   (e_r.md_div),
    .busy  (md_busy)
  );

  // Stall when a producer in E or M cannot deliver before D consumes the operand.
  always_comb begin
    stall_rs_s = (A1_D != 5'd0) &&
                 (((e_r.a3 == A1_D) && (e_r.tnew > Tuse_rs_D)) ||
                  ((m_r.a3 == A1_D) && (m_r.tnew > Tuse_rs_D)));
    stall_rt_s = (A2_D != 5'd0) &&
                 (((e_r.a3 == A2_D) && (e_r.tnew > Tuse_rt_D)) ||
                  ((m_r.a3 == A2_D) && (m_r.tnew > Tuse_rt_D)));
    stall_md_s = md_use_D && (md_busy || e_r.md_start);
    stall_s    = stall_rs_s | stall_rt_s | stall_md_s;
  end

  // Forwarding select, youngest ready producer first.
  always_comb begin
    Fwd_rs_D = fwd_pick(fwd_hit(A1_D, e_r.a3, e_r.tnew),
                        fwd_hit(A1_D, m_r.a3, m_r.tnew),
                        fwd_hit(A1_D, w_r.a3, w_r.tnew));
    Fwd_rt_D = fwd_pick(fwd_hit(A2_D, e_r.a3, e_r.tnew),
                        fwd_hit(A2_D, m_r.a3, m_r.tnew),
                        fwd_hit(A2_D, w_r.a3, w_r.tnew));
    Fwd_rs_E = fwd_pick(1'b0,
                        fwd_hit(e_r.a1, m_r.a3, m_r.tnew),
                        fwd_hit(e_r.a1, w_r.a3, w_r.tnew));
    Fwd_rt_E = fwd_pick(1'b0,
                        fwd_hit(e_r.a2, m_r.a3, m_r.tnew),
                        fwd_hit(e_r.a2, w_r.a3, w_r.tnew));
  end

  assign Stall_F = stall_s;
  assign Stall_D = stall_s;
  assign Flush_E = stall_s;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios followed by
// random instruction streams, all checked against an issue-history model.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] A1_D, A2_D, A3_D;
  logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_D_E;
  logic       md_use_D, md_start_D, md_div_D;
  logic       Stall_F, Stall_D, Flush_E, md_busy;
  logic [1:0] Fwd_rs_D, Fwd_rt_D, Fwd_rs_E, Fwd_rt_E;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .A1_D(A1_D), .A2_D(A2_D),
    .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D), .A3_D(A3_D),
    .Tnew_D_E(Tnew_D_E), .md_use_D(md_use_D), .md_start_D(md_start_D),
    .md_div_D(md_div_D), .Stall_F(Stall_F), .Stall_D(Stall_D),
    .Flush_E(Flush_E), .Fwd_rs_D(Fwd_rs_D), .Fwd_rt_D(Fwd_rt_D),
    .Fwd_rs_E(Fwd_rs_E), .Fwd_rt_E(Fwd_rt_E), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // One instruction as issued into E, with the cycle index as its array slot.
  typedef struct {
    logic [4:0] a1, a2, a3;
    int         tnew;
    bit         st, dv;
  } ins_t;

  ins_t rec [0:4095];
  int   t = 0;
  int   last_rst = -1;
  int   total = 0;
  int   passed = 0;
  logic obs_stall, obs_busy;
  logic [1:0] obs_rs_d, obs_rt_d, obs_rs_e, obs_rt_e;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, t);
  endtask

  // Instruction that entered E k cycles ago as seen now; tnew counts down with age.
  function automatic ins_t stage(input int k);
    ins_t r;
    int   c;
    c = t - k;
    if (c < 0 || c <= last_rst) begin
      r = '{a1: 5'd0, a2: 5'd0, a3: 5'd0, tnew: 0, st: 1'b0, dv: 1'b0};
    end else begin
      r = rec[c];
      r.tnew = (r.tnew - (k - 1) < 0) ? 0 : r.tnew - (k - 1);
    end
    return r;
  endfunction

  function automatic bit hit(input ins_t s, input logic [4:0] src);
    return (s.a3 != 5'd0) && (s.a3 == src) && (s.tnew == 0);
  endfunction

  function automatic bit must_wait(input ins_t s, input logic [4:0] src, input int tuse);
    return (s.a3 == src) && (s.tnew > tuse);
  endfunction

  // Unit is busy from the cycle after a start leaves E for lat cycles.
  function automatic bit model_busy();
    bit b = 1'b0;
    for (int c = t - 12; c <= t - 2; c++) begin
      if (c >= 0 && c > last_rst && rec[c].st && t <= c + 1 + (rec[c].dv ? 10 : 5))
        b = 1'b1;
    end
    return b;
  endfunction

  task automatic step(input logic rst, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [4:0] a3, input int tu_rs, input int tu_rt,
                      input int tn, input logic mu, input logic ms, input logic md);
    ins_t se, sm, sw, d;
    bit   e_stall, e_busy;
    int   e_rs_d, e_rt_d, e_rs_e, e_rt_e;
    reset = rst; A1_D = a1; A2_D = a2; A3_D = a3;
    Tuse_rs_D = tu_rs[1:0]; Tuse_rt_D = tu_rt[1:0]; Tnew_D_E = tn[1:0];
    md_use_D = mu; md_start_D = ms; md_div_D = md;
    #4;
    se = stage(1); sm = stage(2); sw = stage(3);
    e_busy  = model_busy();
    e_stall = ((a1 != 5'd0) && (must_wait(se, a1, tu_rs) || must_wait(sm, a1, tu_rs))) ||
              ((a2 != 5'd0) && (must_wait(se, a2, tu_rt) || must_wait(sm, a2, tu_rt))) ||
              (mu && (e_busy || se.st));
    e_rs_d = hit(se, a1) ? 1 : hit(sm, a1) ? 2 : hit(sw, a1) ? 3 : 0;
    e_rt_d = hit(se, a2) ? 1 : hit(sm, a2) ? 2 : hit(sw, a2) ? 3 : 0;
    e_rs_e = hit(sm, se.a1) ? 2 : hit(sw, se.a1) ? 3 : 0;
    e_rt_e = hit(sm, se.a2) ? 2 : hit(sw, se.a2) ? 3 : 0;
    obs_stall = Stall_F; obs_busy = md_busy;
    obs_rs_d = Fwd_rs_D; obs_rt_d = Fwd_rt_D; obs_rs_e = Fwd_rs_E; obs_rt_e = Fwd_rt_E;
    chk("Stall_F", {4'd0, Stall_F}, {4'd0, e_stall});
    chk("Stall_D", {4'd0, Stall_D}, {4'd0, e_stall});
    chk("Flush_E", {4'd0, Flush_E}, {4'd0, e_stall});
    chk("md_busy", {4'd0, md_busy}, {4'd0, e_busy});
    chk("Fwd_rs_D", {3'd0, Fwd_rs_D}, e_rs_d[4:0]);
    chk("Fwd_rt_D", {3'd0, Fwd_rt_D}, e_rt_d[4:0]);
    chk("Fwd_rs_E", {3'd0, Fwd_rs_E}, e_rs_e[4:0]);
    chk("Fwd_rt_E", {3'd0, Fwd_rt_E}, e_rt_e[4:0]);
    d = '{a1: a1, a2: a2, a3: a3, tnew: tn, st: ms, dv: md};
    if (e_stall) d = '{a1: 5'd0, a2: 5'd0, a3: 5'd0, tnew: 0, st: 1'b0, dv: 1'b0};
    rec[t] = d;
    if (rst) last_rst = t;
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic nop();
    step(1'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    logic rst_r, mu_r, ms_r;
    @(posedge clk);
    #1;
    step(1'b1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    // Post-reset: arbitrary D operands, no md access.
    step(1'b0, 5'd5, 5'd6, 5'd7, 0, 0, 2, 1'b0, 1'b0, 1'b0);
    chk("rst_stall", {4'd0, obs_stall}, 5'd0);
    chk("rst_busy", {4'd0, obs_busy}, 5'd0);
    chk("rst_fwd_rs_d", {3'd0, obs_rs_d}, 5'd0);
    repeat (3) nop();

    // Load-use.
    step(1'b0, 5'd0, 5'd0, 5'd8, 0, 0, 2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd8, 5'd0, 5'd11, 1, 2, 1, 1'b0, 1'b0, 1'b0);
    chk("lu_stall1", {4'd0, obs_stall}, 5'd1);
    step(1'b0, 5'd8, 5'd0, 5'd11, 1, 2, 1, 1'b0, 1'b0, 1'b0);
    chk("lu_stall2", {4'd0, obs_stall}, 5'd0);
    nop();
    chk("lu_fwd_rs_e", {3'd0, obs_rs_e}, 5'd3);
    repeat (3) nop();

    // Branch after ALU.
    step(1'b0, 5'd0, 5'd0, 5'd9, 0, 0, 1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd9, 5'd0, 5'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("br_stall1", {4'd0, obs_stall}, 5'd1);
    step(1'b0, 5'd9, 5'd0, 5'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("br_stall2", {4'd0, obs_stall}, 5'd0);
    chk("br_fwd_rs_d", {3'd0, obs_rs_d}, 5'd2);
    repeat (3) nop();

    // $0 destination.
    step(1'b0, 5'd0, 5'd0, 5'd0, 0, 0, 2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd3, 0, 0, 1, 1'b0, 1'b0, 1'b0);
    chk("r0_stall", {4'd0, obs_stall}, 5'd0);
    chk("r0_fwd", {1'b0, obs_rs_d, obs_rt_d}, 5'd0);
    repeat (3) nop();

    // Div then mfhi.
    step(1'b0, 5'd1, 5'd2, 5'd0, 1, 1, 0, 1'b1, 1'b1, 1'b1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 5'd0, 5'd0, 5'd4, 0, 0, 1, 1'b1, 1'b0, 1'b0);
      if (!obs_stall) break;
      n++;
    end
    chk("div_stall_cycles", n[4:0], 5'd11);
    repeat (3) nop();

    // Reset in the middle of a multiply.
    step(1'b0, 5'd1, 5'd2, 5'd0, 1, 1, 0, 1'b1, 1'b1, 1'b0);
    nop();
    nop();
    step(1'b0, 5'd0, 5'd0, 5'd12, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("mult_busy_before_rst", {4'd0, obs_busy}, 5'd1);
    step(1'b0, 5'd12, 5'd12, 5'd0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("rst_mid_busy", {4'd0, obs_busy}, 5'd0);
    chk("rst_mid_stall", {4'd0, obs_stall}, 5'd0);
    chk("rst_mid_fwd", {1'b0, obs_rs_d, obs_rt_d}, 5'd0);
    repeat (3) nop();

    // Store data behind ALU.
    step(1'b0, 5'd0, 5'd0, 5'd10, 0, 0, 1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd1, 5'd10, 5'd0, 1, 2, 0, 1'b0, 1'b0, 1'b0);
    chk("sw_stall", {4'd0, obs_stall}, 5'd0);
    nop();
    chk("sw_fwd_rt_e", {3'd0, obs_rt_e}, 5'd2);

    // Random streams with small register numbers to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      rst_r = ($urandom_range(0, 59) == 0);
      ms_r  = ($urandom_range(0, 7) == 0);
      mu_r  = ms_r | ($urandom_range(0, 5) == 0);
      step(rst_r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
           int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
           mu_r, ms_r, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
